wb_stage: RTL

- Write-back stage of the five-stage MIPS pipeline. Sits directly downstream of the memory-access stage and consumes its 120-bit MEM->WB bus.
- Owns the architectural HI/LO registers and the CP0 STATUS/CAUSE/EPC registers.
- Produces the register-file write port and resolves syscall, overflow and eret.
- Emits a one-cycle cancel plus redirect target to the fetch stage.

---
 rtl/wb_stage_if.sv | 23 ++
 rtl/wb_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM->WB input bus and write-back result signals
interface wb_stage_if;
    logic         WB_valid;
    logic [119:0] MEM_WB_bus_r;
    logic         rf_wen;
    logic [4:0]   rf_wdest;
    logic [31:0]  rf_wdata;
    logic         WB_over;
    logic [4:0]   WB_wdest;
    logic         cancel;
    logic [32:0]  exc_bus;
    logic [31:0]  WB_pc;

    modport master (
        output WB_valid, MEM_WB_bus_r,
        input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, cancel, exc_bus, WB_pc
    );

    modport slave (
        input  WB_valid, MEM_WB_bus_r,
        output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, cancel, exc_bus, WB_pc
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage with HI/LO and CP0 STATUS/CAUSE/EPC
module wb_stage #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    reset,
    wb_stage_if.slave wb
);
    localparam logic [7:0]  CP0_STATUS  = {5'd12, 3'd0};
    localparam logic [7:0]  CP0_CAUSE   = {5'd13, 3'd0};
    localparam logic [7:0]  CP0_EPC     = {5'd14, 3'd0};
    // Only IM[7:0], EXL and IE are implemented in STATUS.
    localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    // Bus field decode.
    logic        unused_bit;
    logic        f_rf_wen;
    logic [4:0]  f_rf_wdest;
    logic [31:0] f_mem_result;
    logic [31:0] f_lo_result;
    logic        f_hi_write, f_lo_write, f_mfhi, f_mflo, f_mtc0, f_mfc0;
    logic [7:0]  f_cp0r_addr;
    logic        f_syscall, f_eret, f_overflow;
    logic [31:0] f_pc;

    assign unused_bit   = wb.MEM_WB_bus_r[119];
    assign f_rf_wen     = wb.MEM_WB_bus_r[118];
    assign f_rf_wdest   = wb.MEM_WB_bus_r[117:113];
    assign f_mem_result = wb.MEM_WB_bus_r[112:81];
    assign f_lo_result  = wb.MEM_WB_bus_r[80:49];
    assign f_hi_write   = wb.MEM_WB_bus_r[48];
    assign f_lo_write   = wb.MEM_WB_bus_r[47];
    assign f_mfhi       = wb.MEM_WB_bus_r[46];
    assign f_mflo       = wb.MEM_WB_bus_r[45];
    assign f_mtc0       = wb.MEM_WB_bus_r[44];
    assign f_mfc0       = wb.MEM_WB_bus_r[43];
    assign f_cp0r_addr  = wb.MEM_WB_bus_r[42:35];
    assign f_syscall    = wb.MEM_WB_bus_r[34];
    assign f_eret       = wb.MEM_WB_bus_r[33];
    assign f_overflow   = wb.MEM_WB_bus_r[32];
    assign f_pc         = wb.MEM_WB_bus_r[31:0];

    logic        exc;
    logic        commit;
    logic [31:0] cp0_rdata;

    // Write-back outputs, redirect, and next values of HI/LO/CP0.
    always_comb begin
        exc    = wb.WB_valid & (f_syscall | f_overflow);
        commit = wb.WB_valid & ~exc;

        cp0_rdata = 32'h0;
        case (f_cp0r_addr)
            CP0_STATUS: cp0_rdata = status_q;
            CP0_CAUSE:  cp0_rdata = cause_q;
            CP0_EPC:    cp0_rdata = epc_q;
            default:    cp0_rdata = 32'h0;
        endcase

        wb.rf_wen   = commit & f_rf_wen;
        wb.rf_wdest = f_rf_wdest;
        wb.rf_wdata = f_mfhi ? hi_q :
                      f_mflo ? lo_q :
                      f_mfc0 ? cp0_rdata : f_mem_result;
        wb.WB_over  = wb.WB_valid;
        wb.WB_wdest = f_rf_wdest & {5{wb.WB_valid}};
        wb.WB_pc    = f_pc;
        wb.cancel   = exc | (wb.WB_valid & f_eret);
        // The eret target is the EPC value held before this cycle's update.
        wb.exc_bus  = {wb.cancel, exc ? EXC_ENTRY : epc_q};

        hi_d     = hi_q;
        lo_d     = lo_q;
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;

        if (commit) begin
            if (f_hi_write) hi_d = f_mem_result;
            if (f_lo_write) lo_d = f_lo_result;
            if (f_mtc0) begin
                case (f_cp0r_addr)
                    CP0_STATUS: status_d = f_mem_result & STATUS_MASK;
                    CP0_EPC:    epc_d    = f_mem_result;
                    default:    ;
                endcase
            end
            if (f_eret) status_d[1] = 1'b0;
        end

        if (exc) begin
            epc_d         = f_pc;
            status_d[1]   = 1'b1;
            cause_d[31]   = 1'b0;
            cause_d[6:2]  = f_overflow ? 5'd12 : 5'd8;
        end
    end

    // Architectural register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            status_q <= 32'h0;
            cause_q  <= 32'h0;
            epc_q    <= 32'h0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end
endmodule
